// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Default 640x480@60 raster constants, the derived totals and
//                sync boundaries, the colour-bar palette and a bar-index helper
//                shared by the VGA scan generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Default raster geometry: 25 MHz pixel rate from a 50 MHz board clock
    localparam int c_clk_div  = 2;
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;

    // Derived totals and sync windows (start inclusive, end exclusive)
    localparam int c_h_total    = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_v_total    = c_v_active + c_v_fp + c_v_sync + c_v_bp;
    localparam int c_hs_start   = c_h_active + c_h_fp;
    localparam int c_hs_end     = c_hs_start + c_h_sync;
    localparam int c_vs_start   = c_v_active + c_v_fp;
    localparam int c_vs_end     = c_vs_start + c_v_sync;

    // Eight equal-width bars across the visible line
    localparam int c_bar_count  = 8;

    // Bar palette, left to right: white, yellow, cyan, green,
    // magenta, red, blue, black
    localparam logic [23:0] c_bar_colour [0:7] = '{
        24'hFFFFFF,
        24'hFFFF00,
        24'h00FFFF,
        24'h00FF00,
        24'hFF00FF,
        24'hFF0000,
        24'h0000FF,
        24'h000000
    };

    // Which bar a horizontal position falls into; a compare ladder keeps the
    // hardware to a handful of comparators instead of a divider.
    function automatic logic [2:0] bar_index(input logic [9:0] h,
                                             input logic [9:0] bar_w);
        logic [2:0] idx;
        logic [9:0] edge_pos;
        idx      = 3'd0;
        edge_pos = bar_w;
        for (int i = 1; i < c_bar_count; i++) begin
            if (h >= edge_pos) begin
                idx = 3'(i);
            end
            edge_pos = edge_pos + bar_w;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_counter
//  Description : Pixel-rate divider plus horizontal/vertical raster counters.
//                Produces the one-clk pixel strobe, the end-of-frame strobe
//                and a glitch-free registered DAC pixel clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_counter
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = c_clk_div,   // must be >= 2
    parameter int H_TOTAL = c_h_total,
    parameter int V_TOTAL = c_v_total
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       pix_tick,
    output logic       end_of_frame,
    output logic       vga_clk
);

    localparam int                 c_div_w    = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [9:0]         c_h_last   = 10'(H_TOTAL - 1);
    localparam logic [9:0]         c_v_last   = 10'(V_TOTAL - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic [c_div_w-1:0] w_div_next;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;
    logic               r_vga_clk;
    logic               w_h_last;
    logic               w_v_last;

    assign pix_tick     = (r_div_cnt == c_div_last);
    assign w_div_next   = pix_tick ? '0 : (r_div_cnt + c_div_one);
    assign w_h_last     = (r_h_cnt == c_h_last);
    assign w_v_last     = (r_v_cnt == c_v_last);
    // Decoded only from counter registers, so it is clean for one full clk
    assign end_of_frame = pix_tick & w_h_last & w_v_last;

    assign h_cnt   = r_h_cnt;
    assign v_cnt   = r_v_cnt;
    assign vga_clk = r_vga_clk;

    // Divider, raster counters and the DAC clock phase; the DAC clock is
    // registered from the next divider value so it tracks div_cnt exactly
    // without combinational glitches on the pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_vga_clk <= (w_div_next >= c_div_half);
            if (pix_tick) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : (r_v_cnt + 10'd1);
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen
//  Description : VGA raster generator for the pong core. Drives scan
//                coordinates px/py to the game core and registers the returned
//                colour onto the DAC pins with sync and blanking aligned to it
//                (one pixel of latency relative to px/py).
//                Optional build macro VGA_TEST_PATTERN_EN adds a test_mode
//                input that replaces the game colour with eight vertical bars.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = c_clk_div,   // must be >= 2
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pixel,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [9:0]  px,
    output logic [9:0]  py,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_tick
);

    localparam int         c_h_tot    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_v_tot    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_h_act_w  = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_act_w  = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  w_h_cnt;
    logic [9:0]  w_v_cnt;
    logic        w_pix_tick;
    logic        w_end_of_frame;
    logic        w_vga_clk;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_video_on;
    logic [23:0] w_colour;

    logic [23:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank_n;

    vga_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (c_h_tot),
        .V_TOTAL (c_v_tot)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .h_cnt        (w_h_cnt),
        .v_cnt        (w_v_cnt),
        .pix_tick     (w_pix_tick),
        .end_of_frame (w_end_of_frame),
        .vga_clk      (w_vga_clk)
    );

    // Sync and blanking decode from the live counters (sync pulses are low)
    assign w_hs_raw   = !((w_h_cnt >= c_hs_start) && (w_h_cnt < c_hs_end));
    assign w_vs_raw   = !((w_v_cnt >= c_vs_start) && (w_v_cnt < c_vs_end));
    assign w_video_on = (w_h_cnt < c_h_act_w) && (w_v_cnt < c_v_act_w);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] c_bar_w = 10'(H_ACTIVE / c_bar_count);
    assign w_colour = test_mode ? c_bar_colour[bar_index(w_h_cnt, c_bar_w)]
                                : pixel;
`else
    assign w_colour = pixel;
`endif

    // Output stage: latch colour, syncs and blanking together once per pixel
    // so all DAC pins carry the same pixel; blanked pixels are forced black.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb     <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else if (w_pix_tick) begin
            r_rgb     <= w_video_on ? w_colour : 24'h000000;
            r_hs      <= w_hs_raw;
            r_vs      <= w_vs_raw;
            r_blank_n <= w_video_on;
        end
    end

    // The counters are registers themselves, so px/py hold for a whole pixel
    assign px          = w_h_cnt;
    assign py          = w_v_cnt;
    assign vga_clk     = w_vga_clk;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = r_rgb[23:16];
    assign vga_g       = r_rgb[15:8];
    assign vga_b       = r_rgb[7:0];
    assign frame_tick  = w_end_of_frame;

endmodule
`default_nettype wire
